// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns the uart byte stream into screen-buffer writes.
// A packet is four bytes {column, row, char, terminator}. Each field is
// range-checked. A good packet produces one single-cycle write. A bad
// packet is consumed in full so that byte alignment is kept, and is then
// dropped with one err_o pulse. A timeout inside a packet returns the
// decoder to the column field so it can resynchronise after a lost byte.
module uart_cmd_decoder #(
    parameter int          N_COL          = 160,
    parameter int          N_ROW          = 64,
    parameter int          N_COL_WIDTH    = 8,
    parameter int          N_ROW_WIDTH    = 6,
    parameter int          N_CHARS_WIDTH  = 7,
    parameter logic [7:0]  TERM_CHAR      = 8'h0A,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_wr_i,
    input  logic [7:0]               rx_data_i,
    output logic                     wr_en_o,
    output logic [N_COL_WIDTH-1:0]   col_o,
    output logic [N_ROW_WIDTH-1:0]   row_o,
    output logic [N_CHARS_WIDTH-1:0] char_o,
    output logic                     err_o,
    output logic                     busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX   = '1;
    localparam logic [8:0]    COL_LIM  = 9'(N_COL);
    localparam logic [8:0]    COL_LIM2 = 9'(2 * N_COL);
    localparam logic [8:0]    ROW_LIM  = 9'(N_ROW);

    typedef enum logic [1:0] {
        S_COL  = 2'd0,
        S_ROW  = 2'd1,
        S_CHAR = 2'd2,
        S_TERM = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     bad_q, bad_d;
    logic                     rx_wr_q;
    logic                     armed_q;
    logic                     byte_ev;
    logic [TW-1:0]            timer_q;
    logic                     timeout;
    logic                     commit, drop;
    logic                     col_ld, row_ld, char_ld;
    logic [N_COL_WIDTH-1:0]   col_stg;
    logic [N_ROW_WIDTH-1:0]   row_stg;
    logic [N_CHARS_WIDTH-1:0] char_stg;
    logic [8:0]               byte9;
    logic [8:0]               col_sub;
    logic [N_COL_WIDTH-1:0]   col_val;

    // A byte is the rising edge of the data-valid level. armed_q masks the
    // edge until rx_wr_i has been seen low, so a level that is already high
    // when reset is released is not taken as a byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wr_q <= 1'b0;
            armed_q <= ~rx_wr_i;
        end else begin
            rx_wr_q <= rx_wr_i;
            armed_q <= armed_q | ~rx_wr_i;
        end
    end

    assign byte_ev = rx_wr_i & ~rx_wr_q & armed_q;
    assign busy_o  = (state_q != S_COL);

    // Columns from N_COL to 2*N_COL-1 fold back onto the visible range.
    assign byte9   = {1'b0, rx_data_i};
    assign col_sub = byte9 - COL_LIM;
    assign col_val = (byte9 >= COL_LIM) ? col_sub[N_COL_WIDTH-1:0]
                                        : byte9[N_COL_WIDTH-1:0];

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = busy_o && (timer_q >= T_LAST) && !byte_ev;

    // Idle timer: runs only inside a packet, restarts on every byte and saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            timer_q <= '0;
        else if (state_q == S_COL || byte_ev)
            timer_q <= '0;
        else if (timer_q != T_MAX)
            timer_q <= timer_q + 1'b1;
    end

    // FSM state register together with the sticky bad-field flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_COL;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bad_q   <= bad_d;
        end
    end

    // Next state, field checks, staging loads and the commit/drop decision.
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        col_ld  = 1'b0;
        row_ld  = 1'b0;
        char_ld = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        if (byte_ev) begin
            case (state_q)
                S_COL: begin
                    bad_d   = (byte9 >= COL_LIM2);
                    col_ld  = 1'b1;
                    state_d = S_ROW;
                end
                S_ROW: begin
                    if (byte9 >= ROW_LIM)
                        bad_d = 1'b1;
                    row_ld  = 1'b1;
                    state_d = S_CHAR;
                end
                S_CHAR: begin
                    if (rx_data_i[7])
                        bad_d = 1'b1;
                    char_ld = 1'b1;
                    state_d = S_TERM;
                end
                S_TERM: begin
                    if (bad_q || rx_data_i != TERM_CHAR)
                        drop = 1'b1;
                    else
                        commit = 1'b1;
                    bad_d   = 1'b0;
                    state_d = S_COL;
                end
                default: begin
                    bad_d   = 1'b0;
                    state_d = S_COL;
                end
            endcase
        end else if (timeout) begin
            bad_d   = 1'b0;
            drop    = 1'b1;
            state_d = S_COL;
        end
    end

    // Staging registers hold the fields of the packet in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_stg  <= '0;
            row_stg  <= '0;
            char_stg <= '0;
        end else begin
            if (col_ld)  col_stg  <= col_val;
            if (row_ld)  row_stg  <= rx_data_i[N_ROW_WIDTH-1:0];
            if (char_ld) char_stg <= rx_data_i[N_CHARS_WIDTH-1:0];
        end
    end

    // Write port: the outputs change only on a commit, and the strobes last one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_o <= 1'b0;
            err_o   <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
            char_o  <= '0;
        end else begin
            wr_en_o <= commit;
            err_o   <= drop;
            if (commit) begin
                col_o  <= col_stg;
                row_o  <= row_stg;
                char_o <= char_stg;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder. It uses a short timeout so that the
// expiry cases finish quickly.
module tb_uart_cmd_decoder;

    localparam int TO = 32;

    logic       clk;
    logic       rst;
    logic       rx_wr;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [7:0] col;
    logic [5:0] row;
    logic [6:0] chr;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic post_wr, post_err;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .rx_wr_i   (rx_wr),
        .rx_data_i (rx_data),
        .wr_en_o   (wr_en),
        .col_o     (col),
        .row_o     (row),
        .char_o    (chr),
        .err_o     (err),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count the cycles in which each strobe is high. A strobe that sticks high counts more than once.
    always @(negedge clk) begin
        if (wr_en === 1'b1) wr_cnt++;
        if (err === 1'b1)   err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one byte: hold the level for h cycles, then keep it low for one cycle.
    // post_wr and post_err capture the strobes in the cycle after the edge.
    task automatic send_byte(input logic [7:0] d, input int h);
        rx_wr   = 1'b1;
        rx_data = d;
        @(posedge clk);
        #1;
        post_wr  = wr_en;
        post_err = err;
        repeat (h - 1) begin
            @(posedge clk);
            #1;
        end
        rx_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] r,
                            input logic [7:0] ch, input logic [7:0] t, input int h);
        send_byte(c, h);
        send_byte(r, h);
        send_byte(ch, h);
        send_byte(t, h);
    endtask

    initial begin
        rst = 1'b1; rx_wr = 1'b1; rx_data = 8'h00;
        post_wr = 1'b0; post_err = 1'b0;
        tick(3);
        check("rst_wr", wr_en, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {col, row, chr}, 0);

        // The level is already high at reset release, so no byte is taken.
        rst = 1'b0;
        tick(3);
        check("rel_high_busy", busy, 0);
        rx_wr = 1'b0;
        tick(2);

        // Basic packet.
        send_byte(8'h05, 1);
        check("busy_mid", busy, 1);
        send_byte(8'h03, 1);
        send_byte(8'h41, 1);
        send_byte(8'h0A, 1);
        check("p1_wr", post_wr, 1);
        check("p1_outs", {col, row, chr}, {8'd5, 6'd3, 7'h41});
        check("p1_wr_low", wr_en, 0);
        check("p1_idle", busy, 0);
        check("p1_cnt", wr_cnt, 1);

        // Folded column and maximum row, sent back to back.
        send_pkt(8'hA5, 8'h3F, 8'h7E, 8'h0A, 1);
        check("p2_wr", post_wr, 1);
        check("p2_outs", {col, row, chr}, {8'd5, 6'd63, 7'h7E});
        send_pkt(8'h9F, 8'h00, 8'h20, 8'h0A, 1);
        check("p3_outs", {col, row, chr}, {8'd159, 6'd0, 7'h20});
        check("p3_cnt", wr_cnt, 3);

        // Bad row, bad char, bad terminator: each gives one err and no write.
        send_pkt(8'h01, 8'h40, 8'h41, 8'h0A, 1);
        check("badrow_err", post_err, 1);
        check("badrow_wr", post_wr, 0);
        send_pkt(8'h01, 8'h02, 8'h80, 8'h0A, 1);
        check("badchr_err", post_err, 1);
        send_pkt(8'h01, 8'h02, 8'h41, 8'h0D, 1);
        check("badterm_err", post_err, 1);
        check("bad_outs", {col, row, chr}, {8'd159, 6'd0, 7'h20});
        check("bad_cnts", {wr_cnt[15:0], err_cnt[15:0]}, {16'd3, 16'd3});

        // Timeout after column and row. The last edge was in cycle k, the task
        // returns in cycle k+2, and the timer reads TO-1 in cycle k+TO.
        send_byte(8'h07, 1);
        send_byte(8'h08, 1);
        tick(TO - 2);
        check("to_pre_busy", busy, 1);
        check("to_pre_err", err, 0);
        tick(1);
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        tick(1);
        check("to_err_low", err, 0);
        send_pkt(8'h0C, 8'h0D, 8'h45, 8'h0A, 1);
        check("to_next_outs", {col, row, chr}, {8'd12, 6'd13, 7'h45});
        check("to_cnts", {wr_cnt[15:0], err_cnt[15:0]}, {16'd4, 16'd4});

        // A byte edge on the exact expiry cycle is taken as the next field.
        send_byte(8'h21, 1);
        tick(TO - 2);
        send_byte(8'h22, 1);
        check("edge_exp_err", post_err, 0);
        check("edge_exp_busy", busy, 1);
        send_byte(8'h23, 1);
        send_byte(8'h0A, 1);
        check("edge_exp_outs", {col, row, chr}, {8'd33, 6'd34, 7'h23});
        check("edge_exp_cnts", {wr_cnt[15:0], err_cnt[15:0]}, {16'd5, 16'd4});

        // A long level per byte still counts as one field.
        send_pkt(8'h10, 8'h20, 8'h30, 8'h0A, 20);
        check("long_outs", {col, row, chr}, {8'd16, 6'd32, 7'h30});
        check("long_cnt", wr_cnt, 6);

        // Reset in the char state discards the packet.
        send_byte(8'h11, 1);
        send_byte(8'h12, 1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("midrst_outs", {col, row, chr}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnts", {wr_cnt[15:0], err_cnt[15:0]}, {16'd6, 16'd4});
        send_pkt(8'h02, 8'h04, 8'h61, 8'h0A, 1);
        check("midrst_next", {col, row, chr}, {8'd2, 6'd4, 7'h61});
        check("final_cnts", {wr_cnt[15:0], err_cnt[15:0]}, {16'd7, 16'd4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
